// File: rtl/dmem_responder.sv
// dmem_responder: word memory with configurable access latency behind valid/ready request and response channels
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic l_wen;
  logic [31:0] l_addr, l_wdata;
  logic [3:0] l_be;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, commit, a_wen, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [3:0] a_be;
  logic [AW-1:0] a_idx;
  assign req_ready = state == IDLE && reset;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  // with zero wait cycles RESP is entered on the accept edge, before the latches hold the request
  assign a_wen = state == IDLE ? req_wen : l_wen;
  assign a_addr = state == IDLE ? req_addr : l_addr;
  assign a_be = state == IDLE ? req_be : l_be;
  assign a_wdata = state == IDLE ? req_wdata : l_wdata;
  assign a_idx = a_addr[AW+1:2];
  assign a_err = a_addr[1:0] != 2'd0 || 64'(a_addr) >= 64'(4 * DEPTH_WORDS);
  assign commit = reset && state != RESP && state_nx == RESP;
  // next-state and wait counter
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
        cnt_nx = 4'(WAIT_CYCLES);
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        state_nx = cnt == 4'd1 ? RESP : WAIT;
      end
      RESP: state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // control state and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (commit) begin
        rsp_err <= a_err;
        rsp_rdata <= a_err || a_wen ? '0 : mem[a_idx];
      end else if (state == RESP && rsp_ready) begin
        rsp_err <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end
  // request capture, only at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      l_wen <= req_wen;
      l_addr <= req_addr;
      l_be <= req_be;
      l_wdata <= req_wdata;
    end
  end
  // storage is never cleared; a store lands only when it reaches RESP without error
  always_ff @(posedge clk) begin
    if (commit && a_wen && !a_err)
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
endmodule
